// File: rtl/i2c_sub_controller.sv
// i2c_sub_controller -- I2C target-side byte/ACK sequencer clocked directly by SCL.
//
// Rising SCL edges advance the FSM and sample SDA. Falling edges update the SDA
// pull-down so the line only changes while SCL is low.
//
// Ports
//   scl            serial clock (only clock)    rst         async reset, active low
//   sda            sampled serial data          start/stop  condition flags, valid at the next rising edge
//   address_match  address checker result       read_bit/write_bit  direction from the address checker
//   read_address   high while the address byte is shifting
//   clock_count    bit index 0..7 inside a byte
//   sda_oe         1 pulls SDA low
//   rx_data/rx_valid/rx_ack   received write byte, valid flag, consume strobe
//   tx_data/tx_req            read byte source and one-cycle request pulse
//   busy           high in every state except IDLE
//
// Optional build macro I2C_NACK_ON_OVERRUN_EN: NACK a write byte that lands while
// rx_valid is still set, and keep the old rx_data.
module i2c_sub_controller #(
  parameter int MAX_BYTES = 16
) (
  input  logic       scl,
  input  logic       rst,
  input  logic       sda,
  input  logic       start,
  input  logic       stop,
  input  logic       address_match,
  input  logic       read_bit,
  input  logic       write_bit,
  output logic       read_address,
  output logic [3:0] clock_count,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic       tx_req_q, tx_req_d;
  logic       wr_nack_q, wr_nack_d;
  logic       rd_q, rd_d, wr_q, wr_d;
  logic       oe_q, oe_d;
  logic       byte_full, overrun;
  logic [7:0] rx_byte;

  assign byte_full = (byte_q == 8'(MAX_BYTES));
  assign rx_byte   = {rx_sr_q[6:0], sda};

`ifdef I2C_NACK_ON_OVERRUN_EN
  assign overrun = rx_valid_q;
`else
  assign overrun = 1'b0;
`endif

  always_ff @(posedge scl or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      byte_q     <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_sr_q    <= '0;
      tx_req_q   <= 1'b0;
      wr_nack_q  <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_sr_q    <= tx_sr_d;
      tx_req_q   <= tx_req_d;
      wr_nack_q  <= wr_nack_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ack;
    tx_sr_d    = tx_sr_q;
    tx_req_d   = 1'b0;
    wr_nack_d  = wr_nack_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    if (start) begin
      // START and repeated START both restart the address phase; start beats stop.
      state_d = ADDR;
      cnt_d   = '0;
      byte_d  = '0;
    end else if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (address_match) begin
              state_d  = ADDR_ACK;
              rd_d     = read_bit;
              wr_d     = write_bit;
              // Request the first read byte so it is ready at the ADDR_ACK exit.
              tx_req_d = read_bit;
            end else begin
              state_d = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (wr_q) begin
            state_d = WR_DATA;
          end else if (rd_q) begin
            state_d = RD_DATA;
            tx_sr_d = tx_data;
          end else begin
            state_d = IDLE;
          end
        end
        WR_DATA: begin
          cnt_d   = cnt_q + 4'd1;
          rx_sr_d = rx_byte;
          if (cnt_q == 4'd7) begin
            cnt_d     = '0;
            state_d   = WR_ACK;
            wr_nack_d = byte_full | overrun;
            // A NACKed byte is not accepted: rx_data keeps the previous byte.
            if (!(byte_full | overrun)) begin
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
              byte_d     = byte_q + 8'd1;
            end
          end
        end
        WR_ACK: state_d = wr_nack_q ? IDLE : WR_DATA;
        RD_DATA: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            state_d = RD_ACK;
            if (!byte_full) byte_d = byte_q + 8'd1;
          end
        end
        RD_ACK: begin
          // Master NACK (sda high) or MAX_BYTES already sent ends the read.
          if (sda || byte_full) begin
            state_d = IDLE;
          end else begin
            state_d  = RD_DATA;
            tx_sr_d  = tx_data;
            tx_req_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // SDA drive value for the coming low phase; index ~cnt selects MSB first.
  always_comb begin
    oe_d = 1'b0;
    case (state_q)
      ADDR_ACK: oe_d = 1'b1;
      WR_ACK:   oe_d = ~wr_nack_q;
      RD_DATA:  oe_d = ~tx_sr_q[~cnt_q[2:0]];
      default:  oe_d = 1'b0;
    endcase
  end

  always_ff @(negedge scl or negedge rst) begin
    if (!rst) oe_q <= 1'b0;
    else      oe_q <= oe_d;
  end

  // STOP/START land on a rising edge; gating by state releases SDA right away
  // instead of waiting for the next falling edge.
  assign sda_oe       = oe_q & (state_q != IDLE) & (state_q != ADDR);
  assign read_address = (state_q == ADDR);
  assign clock_count  = cnt_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign tx_req       = tx_req_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/i2c_sub_controller.md
I2C_SUB_CONTROLLER -- requirements
Module: i2c_sub_controller

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 16, meaning the number of data bytes accepted or sent per transfer before the block NACKs or stops.
REQ-002 SHALL have port scl, input, 1 bit: the I2C serial clock and the only clock; the block uses its rising and falling edges.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port sda, input, 1 bit: sampled serial data.
REQ-005 SHALL have ports start and stop, input, 1 bit each: level flags from the condition detector, held high until the next scl rising edge.
REQ-006 SHALL have ports address_match, read_bit and write_bit, input, 1 bit each, driven by the address checker.
REQ-007 SHALL have ports read_address (output, 1 bit) and clock_count (output, 4 bits), which sequence the address checker.
REQ-008 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low, 0 releases it.
REQ-009 SHALL have ports rx_data (output, 8 bits) and rx_valid (output, 1 bit) for the received write byte, and rx_ack (input, 1 bit) as its consume strobe.
REQ-010 SHALL have ports tx_data (input, 8 bits), tx_req (output, 1-cycle pulse) requesting the next read byte, and busy (output, 1 bit).

Function
REQ-011 SHALL implement the FSM states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA and RD_ACK, updated on scl rising edges.
REQ-012 SHALL treat any scl rising edge with start=1 as follows: enter ADDR with clock_count=0, regardless of state; a repeated START is handled identically.
REQ-013 SHALL treat stop=1 at an scl rising edge as follows: go to IDLE, set sda_oe=0 and busy=0; if stop and start are both high, start wins.
REQ-014 SHALL hold read_address=1 only in ADDR, and SHALL have clock_count increment 0..7 on each rising edge in ADDR, WR_DATA and RD_DATA.
REQ-015 SHALL, in ADDR at clock_count=7: register address_match; if it is 1, go to ADDR_ACK, otherwise go to IDLE (no ACK, ignore the bus until the next start).
REQ-016 SHALL, in ADDR_ACK, drive sda_oe=1 from the falling edge after the 8th bit until the falling edge after the 9th bit.
REQ-017 SHALL, after ADDR_ACK: go to WR_DATA if write_bit=1; if read_bit=1, go to RD_DATA and pulse tx_req during the ADDR_ACK cycle.
REQ-018 SHALL, in WR_DATA, shift sda in MSB first on rising edges.
REQ-019 SHALL, at clock_count=7 in WR_DATA, load rx_data and set rx_valid=1; rx_valid SHALL clear on an rx_ack rising-edge sample.
REQ-020 SHALL, in WR_ACK, ACK (sda_oe=1 over the 9th clock) unless the byte count equals MAX_BYTES, in which case it NACKs and returns to IDLE.
REQ-021 SHALL, in RD_DATA, drive sda_oe = ~tx_bit, changed on falling edges, MSB first; tx_data is latched at the ADDR_ACK/RD_ACK exit.
REQ-022 SHALL, in RD_ACK, release SDA and sample sda on the 9th rising edge: 0 continues to RD_DATA with a tx_req pulse; 1 (master NACK) goes to IDLE.
REQ-023 SHALL keep a byte counter that resets at START, saturates at MAX_BYTES, and is 8-bit wide; clock_count SHALL wrap 7->0 only via an ACK state.
REQ-024 SHALL hold busy=1 in every state except IDLE.

Reset
REQ-025 SHALL, while rst=0 (independent of scl), force: state=IDLE, clock_count=0, read_address=0, sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, busy=0, byte counter=0.
REQ-026 SHALL, when reset is asserted mid-transfer, release SDA immediately, and SHALL ignore bus activity until the next start.

Configuration
REQ-027 SHALL provide the macro I2C_NACK_ON_OVERRUN_EN; when defined, WR_ACK SHALL NACK and go to IDLE if rx_valid is still 1 when a new byte completes, and rx_data SHALL keep the old byte.
REQ-028 SHALL, when I2C_NACK_ON_OVERRUN_EN is undefined, overwrite rx_data, keep rx_valid=1, and ACK normally.

Verification
REQ-029 SHALL cover: start, address 1100110, R/W=0, matching -> sda_oe=1 during the 9th clock, state WR_DATA, busy=1.
REQ-030 SHALL cover: start, address 1010101, mismatch -> sda_oe stays 0, state IDLE, rx_valid never set.
REQ-031 SHALL cover: write of byte 0xA5 -> rx_data=0xA5, rx_valid=1 after the 8th rising edge, then ACK; rx_ack clears rx_valid.
REQ-032 SHALL cover: read with tx_data=0x3C and master NACK -> SDA bits 0,0,1,1,1,1,0,0, one tx_req pulse, then IDLE.
REQ-033 SHALL cover: with the macro defined, two bytes and no rx_ack -> the second byte is NACKed and rx_data keeps the first value.
REQ-034 SHALL cover: rst=0 at clock_count=4 of RD_DATA -> sda_oe=0 and busy=0 immediately; a repeated start mid-byte -> ADDR with clock_count=0.
